in_port_ff: RTL and testbench
=============================

# in_port_ff

Synchronous 4-bit input port: the bus-facing counterpart of the LED output register. It captures the 4 external switches when the operator presses a debounced "enter" button and holds that nibble. When the CPU enables a read, it drives the nibble onto the shared 4-bit data bus and releases the bus (4'bzzzz) at all other times. It also flags unread data and overruns for the control unit.

## Interface
Parameters:
- DB_CYCLES, 16, consecutive stable synchronized samples required to accept a button level change; legal range is 2 or more.
- CNT_W, $clog2(DB_CYCLES), width of the debounce counter.

Ports:
- clk  in  1  single system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- sw  in  4  asynchronous switch inputs.
- btn  in  1  asynchronous, bouncy enter button; active-high.
- enable  in  1  bus read enable from the control unit.
- D  inout  4  shared data bus; driven only while enable=1 and reset=0, otherwise 4'bzzzz.
- ready  out  1  captured nibble not yet read; reset value 0.
- overrun  out  1  a capture overwrote an unread nibble; reset value 0.

## Operation
- **Synchronizers:** sw and btn each pass through a 2-flop synchronizer, reset to 0. This produces sw_s and btn_s.
- **Debounce FSM** (4 states, reset state IDLE_LOW):
  - IDLE_LOW: if btn_s=1, go to CHK_HIGH with cnt=1.
  - CHK_HIGH:
    - if btn_s=0, go to IDLE_LOW with cnt=0;
    - else if cnt==DB_CYCLES-1, go to IDLE_HIGH, cnt=0, and assert press for this edge;
    - else cnt++.
  - IDLE_HIGH: if btn_s=0, go to CHK_LOW with cnt=1.
  - CHK_LOW:
    - if btn_s=1, go to IDLE_HIGH with cnt=0;
    - else if cnt==DB_CYCLES-1, go to IDLE_LOW with cnt=0 (no press);
    - else cnt++.
- **Capture** (on press): hold <= sw_s and ready <= 1. If ready was already 1 and enable=0 that cycle, overrun <= 1. The newest nibble always wins.
- **Read:** while enable=1, D = hold combinationally. At the next posedge, ready <= 0 and overrun <= 0.
- **Capture and read in the same cycle:** D shows the old hold during that cycle. After the edge, hold is the new value, ready=1 and overrun=0.
- **Repeated reads:** enable held for several cycles keeps driving hold. Reading with ready=0 is legal and returns the last hold (0 after reset).
- **Press counting:** exactly one press per debounced low-to-high transition. Holding the button produces no repeat captures.

## Timing
- **Reset:** async assert clears hold=0, ready=0, overrun=0, FSM=IDLE_LOW, cnt=0 and synchronizers to 0. D goes to z immediately.
- **Button held through reset release:** it is treated as a new press after the full debounce latency.
- **Press latency:** btn rises before edge k and stays stable. ready is 1 after edge k+1+DB_CYCLES (k+17 at default).
- **Switch setup:** sw is sampled as sw_s at the capture edge, so sw must be stable by edge capture-2.
- **Glitches:** any btn_s glitch shorter than DB_CYCLES samples during a CHK state returns the FSM to its idle state and restarts counting.
- **Read clear:** ready and overrun clear one edge after the enable cycle.
- **Bus drive:** D drive has zero-cycle latency from enable, i.e. it is combinational.

## Structure
- Shared package nibbler_pkg holds:
  - BUS_W = 4;
  - the typedef enum logic [1:0] db_state_t {IDLE_LOW, CHK_HIGH, IDLE_HIGH, CHK_LOW}.
- Sub-module in_debounce contains the btn synchronizer, the FSM and the counter, and outputs a one-cycle press pulse. It is reusable for other front-panel buttons.
- The top level contains the sw synchronizer, hold, ready, overrun and the tri-state driver.

## Test plan
- **Reset:** assert reset mid-debounce (CHK_HIGH, cnt=7) -> ready=0, overrun=0, D=zzzz immediately; after release, btn held high -> ready at release edge+17.
- **Clean press:** sw=4'b1010, btn rises before edge 0 -> ready=1 after edge 17; enable=1 -> D=4'b1010; ready=0 after the next edge.
- **Bounce:** btn toggles 1/0 every 5 cycles for 40 cycles then stays 1 with sw=4'b0110 -> exactly one capture, ready=1 after 17 stable cycles, hold=4'b0110.
- **Overrun:** press with sw=4'b0011, no read, then press with sw=4'b1100 -> overrun=1, read returns 4'b1100, ready and overrun both 0 after the read edge.
- **Simultaneous capture and read:** old hold 4'b0001, enable=1 on the press edge with sw=4'b1111 -> D=4'b0001 that cycle; after the edge ready=1, overrun=0, next read D=4'b1111.
- **Bus release and hold-down:** enable=0 -> D=zzzz in every cycle; btn held 100 cycles -> exactly one capture; release plus re-press -> second capture.

Source files
------------

// File: rtl/nibbler_pkg.sv
// Shared types for the nibbler front panel: bus width and debounce states.
// No logic; no latency.
// No flow control.
package nibbler_pkg;

    localparam int BUS_W = 4;

    typedef enum logic [1:0] {
        IDLE_LOW,
        CHK_HIGH,
        IDLE_HIGH,
        CHK_LOW
    } db_state_t;

endpackage

// File: rtl/in_debounce.sv
// Button synchronizer + debouncer; emits a one-cycle press per debounced rising edge.
// Latency: press is high in the cycle before edge k+1+DB_CYCLES when btn rises before edge k.
// No backpressure: press is a pulse and must be consumed on the edge it is high.
module in_debounce
    import nibbler_pkg::*;
#(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             btn_m;
    logic             btn_s;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            btn_m <= btn;
            btn_s <= btn_m;
        end
    end

    // cnt holds the number of consecutive samples seen at the candidate new level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE_LOW;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE_LOW: begin
                    if (btn_s) begin
                        state <= CHK_HIGH;
                        cnt   <= CNT_ONE;
                    end
                end
                CHK_HIGH: begin
                    if (!btn_s) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE_HIGH: begin
                    if (!btn_s) begin
                        state <= CHK_LOW;
                        cnt   <= CNT_ONE;
                    end
                end
                CHK_LOW: begin
                    if (btn_s) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Decoded rather than registered so the capture lands on the same edge the FSM commits.
    assign press = (state == CHK_HIGH) && btn_s && (cnt == CNT_LAST);

endmodule

// File: rtl/in_port_ff.sv
// Front-panel input port: captures the switch nibble on a debounced press, drives it on D when read.
// Latency: ready rises DB_CYCLES+1 edges after btn rises; D follows enable combinationally.
// No backpressure: a capture over unread data overwrites it and raises overrun.
module in_port_ff
    import nibbler_pkg::*;
#(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BUS_W-1:0] sw,
    input  logic             btn,
    input  logic             enable,
    inout  wire  [BUS_W-1:0] D,
    output logic             ready,
    output logic             overrun
);

    logic [BUS_W-1:0] sw_m;
    logic [BUS_W-1:0] sw_s;
    logic [BUS_W-1:0] hold;
    logic             press;

    in_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .press (press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_m <= '0;
            sw_s <= '0;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
        end
    end

    // A read in the capture cycle consumes the old nibble, so the new one is fresh, not an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold    <= '0;
            ready   <= 1'b0;
            overrun <= 1'b0;
        end else if (press) begin
            hold    <= sw_s;
            ready   <= 1'b1;
            overrun <= enable ? 1'b0 : (overrun | ready);
        end else if (enable) begin
            ready   <= 1'b0;
            overrun <= 1'b0;
        end
    end

    assign D = (enable && !reset) ? hold : {BUS_W{1'bz}};

endmodule

// File: tb/tb_in_port_ff.sv
// Scoreboarded random/directed bench for in_port_ff against a run-length debounce model.
// D is pulled up here, so a released bus reads back as 4'b1111.
module tb_in_port_ff;

    localparam int DB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw;
    logic       btn;
    logic       enable;
    tri1  [3:0] D;
    logic       ready;
    logic       overrun;

    in_port_ff #(.DB_CYCLES(DB)) dut (
        .clk     (clk),
        .reset   (reset),
        .sw      (sw),
        .btn     (btn),
        .enable  (enable),
        .D       (D),
        .ready   (ready),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rdy;
        logic       ovr;
        logic [3:0] d;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_press = 0;

    // Reference model: two-sample delay lines, then a debounced level that flips
    // once DB consecutive samples disagree with it.
    logic       m_b1, m_b2, m_lvl;
    logic [3:0] m_sw1, m_sw2, m_hold;
    logic       m_ready, m_overrun;
    int         m_run;

    task automatic model_clear();
        m_b1 = 0; m_b2 = 0; m_lvl = 0; m_run = 0;
        m_sw1 = '0; m_sw2 = '0; m_hold = '0;
        m_ready = 0; m_overrun = 0;
    endtask

    task automatic model_edge();
        logic       bs;
        logic [3:0] ss;
        logic       pressed;
        if (reset) begin
            model_clear();
            return;
        end
        bs = m_b2;
        ss = m_sw2;
        m_b2 = m_b1;   m_b1 = btn;
        m_sw2 = m_sw1; m_sw1 = sw;
        pressed = 0;
        if (bs != m_lvl) begin
            m_run++;
            if (m_run == DB) begin
                m_lvl = bs;
                m_run = 0;
                pressed = bs;
            end
        end else begin
            m_run = 0;
        end
        if (pressed) begin
            n_press++;
            m_overrun = enable ? 1'b0 : (m_overrun | m_ready);
            m_ready = 1;
            m_hold = ss;
        end else if (enable) begin
            m_ready = 0;
            m_overrun = 0;
        end
    endtask

    task automatic cyc(input logic b, input logic [3:0] s, input logic e, input logic r);
        exp_t x;
        @(negedge clk);
        btn = b; sw = s; enable = e; reset = r;
        #1;
        if (r) model_clear();
        x.rdy = m_ready;
        x.ovr = m_overrun;
        x.d   = (e && !r) ? m_hold : 4'b1111;
        q.push_back(x);
        model_edge();
    endtask

    task automatic run(input int n, input logic b, input logic [3:0] s, input logic e, input logic r);
        for (int i = 0; i < n; i++) cyc(b, s, e, r);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("ready",   {3'b000, ready},   {3'b000, x.rdy});
                chk("overrun", {3'b000, overrun}, {3'b000, x.ovr});
                chk("bus_D",   D,                 x.d);
            end
        end
    end

    initial begin : stimulus
        logic       lvl;
        int         len;
        int         press_before;
        reset = 1; btn = 0; sw = '0; enable = 0;
        model_clear();

        // Reset with a read request: bus must stay released.
        run(3, 0, 4'b0000, 1, 1);
        run(20, 0, 4'b0000, 0, 0);
        run(1, 0, 4'b0000, 1, 0);

        // Reset mid-debounce, button held through release.
        run(9, 1, 4'b0101, 0, 0);
        run(2, 1, 4'b0101, 0, 1);
        run(20, 1, 4'b0101, 0, 0);
        run(1, 1, 4'b0101, 1, 0);
        run(20, 0, 4'b0101, 0, 0);

        // Clean press, then a two-cycle read.
        run(3, 0, 4'b1010, 0, 0);
        run(20, 1, 4'b1010, 0, 0);
        run(2, 1, 4'b1010, 1, 0);
        run(20, 0, 4'b1010, 0, 0);

        // Bounce, then stable high.
        for (int i = 0; i < 8; i++) run(5, (i % 2 == 0), 4'b0110, 0, 0);
        run(20, 1, 4'b0110, 0, 0);
        run(1, 1, 4'b0110, 1, 0);
        run(20, 0, 4'b0110, 0, 0);

        // Overrun.
        run(20, 1, 4'b0011, 0, 0);
        run(20, 0, 4'b1100, 0, 0);
        run(20, 1, 4'b1100, 0, 0);
        run(1, 1, 4'b1100, 1, 0);
        run(3, 1, 4'b1100, 0, 0);
        run(20, 0, 4'b1100, 0, 0);

        // Read on the capture edge.
        run(20, 1, 4'b0001, 0, 0);
        run(1, 1, 4'b0001, 1, 0);
        run(20, 0, 4'b1111, 0, 0);
        run(17, 1, 4'b1111, 0, 0);
        run(1, 1, 4'b1111, 1, 0);
        run(5, 1, 4'b1111, 0, 0);
        run(1, 1, 4'b1111, 1, 0);
        run(20, 0, 4'b1111, 0, 0);

        // Long hold-down gives one capture; release and re-press gives another.
        press_before = n_press;
        run(100, 1, 4'b0111, 0, 0);
        run(1, 1, 4'b0111, 1, 0);
        run(20, 0, 4'b1000, 0, 0);
        run(20, 1, 4'b1000, 0, 0);
        run(1, 1, 4'b1000, 1, 0);
        run(20, 0, 4'b1000, 0, 0);
        chk("holddown_presses", 4'(n_press - press_before), 4'd2);

        // Random segments of steady button level with random reads and switches.
        for (int seg = 0; seg < 150; seg++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++)
                cyc(lvl, 4'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 999) == 0));
        end
        run(3, 0, 4'b0000, 0, 0);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
